// File: rtl/cla_seq_adder64.sv
// Multi-precision add sequencer: computes a NWORDS*16-bit sum by time-multiplexing one
// external 16-bit carry-lookahead adder, least-significant word first. The inter-word
// carry lives in a register between cycles.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start, a, b,        request; operands and carry_in latched when start is accepted
//   carry_in            (in IDLE or DONE)
//   busy, done          busy while words are being added; done is a one-cycle result pulse
//   sum, carry_out      registered result, held until the next operation overwrites it
//   add_a, add_b,       combinational drive to the shared cla_adder16
//   add_cin
//   add_sum, add_cout   combinational result from the shared cla_adder16
module cla_seq_adder64 #(
  parameter int unsigned NWORDS = 4,
  parameter int unsigned WORD_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [NWORDS*WORD_W-1:0]   a,
  input  logic [NWORDS*WORD_W-1:0]   b,
  input  logic                       carry_in,
  output logic                       busy,
  output logic                       done,
  output logic [NWORDS*WORD_W-1:0]   sum,
  output logic                       carry_out,
  output logic [WORD_W-1:0]          add_a,
  output logic [WORD_W-1:0]          add_b,
  output logic                       add_cin,
  input  logic [WORD_W-1:0]          add_sum,
  input  logic                       add_cout
);

  localparam int unsigned Width = NWORDS * WORD_W;
  localparam int unsigned IdxW  = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NWORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [Width-1:0]  a_q, a_d;
  logic [Width-1:0]  b_q, b_d;
  logic [Width-1:0]  sum_q, sum_d;
  logic              carry_q, carry_d;
  logic              cout_q, cout_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    unique case (state_q)
      // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        sum_d[WORD_W*idx_q +: WORD_W] = add_sum;
        carry_d = add_cout;
        idx_d   = idx_q + IdxW'(1);
        if (idx_q == LastIdx) begin
          cout_d  = add_cout;
          // Park idx at word 0 so the adder sees word 0 outside RUN.
          idx_d   = '0;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Reset has priority over any request in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  // Adder drive comes from registers only, so operand changes after acceptance are invisible.
  always_comb begin
    add_a   = a_q[WORD_W*idx_q +: WORD_W];
    add_b   = b_q[WORD_W*idx_q +: WORD_W];
    add_cin = carry_q;
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule
